bcd_conv_seq: RTL and testbench
===============================

BCD_CONV_SEQ -- requirements
Module: bcd_conv_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter LEAD_BLANK, default 0; when 1, leading-zero digits are replaced with the blank code 4'hF.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a conversion request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, which cancels an in-progress conversion.
REQ-006 The block SHALL have port bin, input, 21, a signed two's-complement operand, sampled with an accepted start.
REQ-007 The block SHALL have port busy, output, 1, high in SHIFT and DONE.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse when bcd_out updates.
REQ-009 The block SHALL have port bcd_out, output, 32: [31:28] sign nibble, [27:0] seven BCD digits, least significant digit in [3:0].

Function
REQ-010 The block SHALL implement FSM states IDLE, SHIFT and DONE, one-hot or encoded at implementer's choice.
REQ-011 In IDLE, start=1 SHALL be accepted: bin is latched, a 21-bit magnitude formed (|bin|, with -1048576 giving 1048576), the sign stored, the scratch BCD field and the iteration counter cleared, and the next state set to SHIFT.
REQ-012 In each SHIFT cycle, every 4-bit digit >= 5 SHALL get +3 (all seven digits evaluated in parallel), then {digits, magnitude} SHALL shift left by 1.
REQ-013 SHIFT SHALL last exactly 21 cycles (counter 0..20); after the 21st cycle the next state SHALL be DONE.
REQ-014 On entering DONE, bcd_out SHALL load {sign nibble, digits}: sign 4'b1110 if the operand is negative, 4'b1111 otherwise; done SHALL be 1 for that single DONE cycle, and the next state SHALL be IDLE.
REQ-015 Latency: start accepted at edge T SHALL produce done=1 in the cycle following edge T+22; back-to-back throughput SHALL be one conversion per 23 cycles.
REQ-016 When LEAD_BLANK=1, every digit above the most significant nonzero digit SHALL be output as 4'hF, with digit 0 never blanked; the value 0 SHALL show a single 0.
REQ-017 start while busy=1, including during DONE, SHALL be ignored with no queuing.
REQ-018 abort=1 in SHIFT SHALL force IDLE on the next edge with no done pulse and bcd_out unchanged; abort SHALL have priority over counter completion; abort in IDLE or DONE SHALL have no effect.
REQ-019 Simultaneous abort and start in IDLE SHALL accept the start.
REQ-020 bcd_out SHALL hold its last value between done pulses.
REQ-021 Negation SHALL be performed at 21-bit width so that every input in [-1048576, 1048575] converts exactly.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, bcd_out=32'hF000_0000 (0xFFFF_FFF0 when LEAD_BLANK=1), and counter and scratch registers cleared.
REQ-023 Reset asserted mid-conversion SHALL discard the conversion; no done pulse SHALL occur after release.
REQ-024 After rst_n deasserts, the first accepted start SHALL behave per REQ-011.

Verification
REQ-025 The bench SHALL apply bin=0, LEAD_BLANK=0 and check bcd_out=0xF000_0000 with done exactly 23 cycles after the start edge.
REQ-026 The bench SHALL check these conversions: bin=1048575 -> 0xF104_8575; bin=-1 -> 0xE000_0001; bin=-1048576 -> 0xE104_8576.
REQ-027 The bench SHALL set LEAD_BLANK=1 and check bin=42 -> 0xFFFF_FF42 and bin=-7 -> 0xEFFF_FFF7.
REQ-028 The bench SHALL start with bin=123, pulse start again with bin=999 at cycle 5, and check a single done with bcd_out=0xF000_0123.
REQ-029 The bench SHALL start with bin=555, assert abort at SHIFT cycle 10, and check no done, bcd_out still holding its prior value, and busy=0 on the next cycle.
REQ-030 The bench SHALL assert rst_n=0 asynchronously at SHIFT cycle 7 and check immediate busy=0, done=0, bcd_out=reset value, and no done after release.

Source files
------------

// File: rtl/bcd_conv_seq.sv
// bcd_conv_seq: sequential double-dabble converter, signed 21-bit binary to sign nibble + seven BCD digits.
// Optional leading-zero blanking replaces high zero digits with 4'hF.
module bcd_conv_seq #(
    parameter bit LEAD_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [20:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out
);
    localparam logic [31:0] RST_BCD = LEAD_BLANK ? 32'hFFFF_FFF0 : 32'hF000_0000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [20:0] mag_q, mag_d;
    logic [27:0] dig_q, dig_d, adj, fmt;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        seen;

    always_comb begin
        for (int i = 0; i < 7; i++)
            adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
    end

    // Digit 0 is never blanked, so zero still shows a single 0.
    always_comb begin
        fmt  = dig_q;
        seen = 1'b0;
        for (int i = 6; i > 0; i--) begin
            seen = seen | (dig_q[4*i +: 4] != 4'd0);
            if (LEAD_BLANK && !seen)
                fmt[4*i +: 4] = 4'hF;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    neg_d   = bin[20];
                    mag_d   = bin[20] ? (~bin + 21'd1) : bin;
                    dig_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    {dig_d, mag_d} = {adj, mag_q} << 1;
                    cnt_d          = cnt_q + 5'd1;
                    state_d        = (cnt_q == 5'd20) ? DONE : SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
                bcd_d   = {neg_q ? 4'hE : 4'hF, fmt};
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bcd_q   <= RST_BCD;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_conv_seq.sv
// tb_bcd_conv_seq: directed checks of bcd_conv_seq with and without leading-zero blanking.
module tb_bcd_conv_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [20:0] bin;
    logic        busy0, done0, busy1, done1;
    logic [31:0] bcd0, bcd1;
    int          checks = 0;
    int          errors = 0;

    bcd_conv_seq #(.LEAD_BLANK(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bin(bin),
        .busy(busy0), .done(done0), .bcd_out(bcd0)
    );
    bcd_conv_seq #(.LEAD_BLANK(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bin(bin),
        .busy(busy1), .done(done1), .bcd_out(bcd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic convert(input string tag, input int v, input logic ab,
                           input logic [31:0] e0, input logic [31:0] e1);
        int k;
        @(negedge clk);
        start = 1'b1;
        bin   = v[20:0];
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        k     = 1;
        chk({tag, " busy"}, {31'd0, busy0}, 32'd1);
        while (!done0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, 32'd23);
        chk({tag, " bcd"}, bcd0, e0);
        chk({tag, " bcd_blank"}, bcd1, e1);
        chk({tag, " done_blank"}, {31'd0, done1}, 32'd1);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, done0}, 32'd0);
    endtask

    initial begin
        int n_done;
        logic [31:0] last;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bin   = '0;
        #12;
        chk("rst busy", {31'd0, busy0}, 32'd0);
        chk("rst done", {31'd0, done0}, 32'd0);
        chk("rst bcd", bcd0, 32'hF000_0000);
        chk("rst bcd_blank", bcd1, 32'hFFFF_FFF0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("zero", 0, 1'b0, 32'hF000_0000, 32'hFFFF_FFF0);
        convert("max", 1048575, 1'b0, 32'hF104_8575, 32'hF104_8575);
        convert("minus1", -1, 1'b1, 32'hE000_0001, 32'hEFFF_FFF1);
        convert("min", -1048576, 1'b0, 32'hE104_8576, 32'hE104_8576);
        convert("p42", 42, 1'b0, 32'hF000_0042, 32'hFFFF_FF42);
        convert("m7", -7, 1'b0, 32'hE000_0007, 32'hEFFF_FFF7);

        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 21'd123;
        n_done = 0;
        last   = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) bin = 21'd999;
            if (done0) begin
                n_done++;
                last = bcd0;
            end
        end
        start = 1'b0;
        chk("busy_start done_count", n_done, 32'd1);
        chk("busy_start bcd", last, 32'hF000_0123);

        // abort mid-shift
        @(negedge clk);
        start = 1'b1;
        bin   = 21'd555;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", {31'd0, busy0}, 32'd0);
        chk("abort done", {31'd0, done0}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done0 || done1) n_done++;
        end
        chk("abort no_done", n_done, 32'd0);
        chk("abort bcd_hold", bcd0, 32'hF000_0123);
        chk("abort bcd_hold_blank", bcd1, 32'hFFFF_F123);

        // asynchronous reset mid-shift
        @(negedge clk);
        start = 1'b1;
        bin   = 21'd777;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 7; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset busy", {31'd0, busy0}, 32'd0);
        chk("areset done", {31'd0, done0}, 32'd0);
        chk("areset bcd", bcd0, 32'hF000_0000);
        chk("areset bcd_blank", bcd1, 32'hFFFF_FFF0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done0 || done1) n_done++;
        end
        chk("areset no_done", n_done, 32'd0);
        chk("areset bcd_hold", bcd0, 32'hF000_0000);

        convert("post_reset", 42, 1'b0, 32'hF000_0042, 32'hFFFF_FF42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
